// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the unified-RAM port controller: length codes, FSM encodings, byte helpers.
// IoGuardEn follows the MEMCTRL_IO_GUARD_EN build macro.
package mem_ctrl_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [1:0] MemLen1 = 2'b00;
  localparam logic [1:0] MemLen2 = 2'b01;
  localparam logic [1:0] MemLen4 = 2'b10;

  // Address bit pair value that selects the IO region.
  localparam logic [1:0] IoSel = 2'b11;

`ifdef MEMCTRL_IO_GUARD_EN
  localparam bit IoGuardEn = 1'b1;
`else
  localparam bit IoGuardEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Length code 11 is treated as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      MemLen1: return 3'd1;
      MemLen2: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{i, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port bundle between the pipeline, mem_ctrl and the byte-wide RAM.
// io_buffer_full exists only when MEMCTRL_IO_GUARD_EN is defined.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic              stallreq_mem;
  logic              stallreq_if;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

`ifdef MEMCTRL_IO_GUARD_EN
  logic              io_buffer_full;
`endif

  // Requesters and the RAM side.
  modport master (
`ifdef MEMCTRL_IO_GUARD_EN
    output io_buffer_full,
`endif
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, stallreq_mem, stallreq_if,
    input  ram_dout, ram_a, ram_wr
  );

  // The controller.
  modport slave (
`ifdef MEMCTRL_IO_GUARD_EN
    input  io_buffer_full,
`endif
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, stallreq_mem, stallreq_if,
    output ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// IDLE-state grant logic: MEM over IF, no grant while a done pulse is out or an IO gap is running.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic idle,
  input  logic if_req,
  input  logic mem_req,
  input  logic mem_we,
  input  logic is_io,
  input  logic io_full,
  input  logic io_gap,
  input  logic if_done,
  input  logic mem_done,
  output logic grant_if,
  output logic grant_mem
);

  logic blocked;
  logic mem_hold;

  always_comb begin
    // A done pulse blocks the grant so the served requester gets a cycle to drop its request.
    blocked   = !idle || if_done || mem_done || io_gap;
    mem_hold  = IoGuardEn && mem_we && is_io && io_full;
    grant_mem = !blocked && mem_req && !mem_hold;
    grant_if  = !blocked && if_req && !grant_mem;
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF/MEM 1/2/4-byte little-endian accesses onto the byte-wide unified RAM port.
// Define MEMCTRL_IO_GUARD_EN to add the io_buffer_full guard on IO-region stores.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int IO_SEL_BIT = 17
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [2:0]        n_q, cnt_q;
  logic [1:0]        io_gap_q;
  logic              io_wr_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_done_q, mem_done_q;
  logic [31:0]       if_inst_q, mem_rdata_q;

  logic              grant_if, grant_mem, is_io, io_full;
  logic              rd_last, wr_last;
  logic [1:0]        rd_idx, wr_idx;
  logic [31:0]       rd_word;

  assign is_io = (bus.mem_addr[IO_SEL_BIT -: 2] == IoSel);
`ifdef MEMCTRL_IO_GUARD_EN
  assign io_full = bus.io_buffer_full;
`else
  assign io_full = 1'b0;
`endif

  mem_ctrl_arb u_arb (
    .idle      (state_q == ST_IDLE),
    .if_req    (bus.if_req),
    .mem_req   (bus.mem_req),
    .mem_we    (bus.mem_we),
    .is_io     (is_io),
    .io_full   (io_full),
    .io_gap    (io_gap_q != 2'd0),
    .if_done   (if_done_q),
    .mem_done  (mem_done_q),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= ST_IDLE;
    else if (rdy)         state_q <= state_d;
  end

  // NOTE: default assignment first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_mem)     state_d = bus.mem_we ? ST_WRITE : ST_READ;
                else if (grant_if) state_d = ST_READ;
      ST_READ:  if (rd_last)       state_d = ST_IDLE;
      ST_WRITE: if (wr_last)       state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Read byte i arrives in READ cycle cnt = i+1; the last capture coincides with cnt == n.
  always_comb begin
    rd_last = (state_q == ST_READ) && (cnt_q == n_q);
    wr_last = (state_q == ST_WRITE) && (cnt_q + 3'd1 == n_q);
    rd_idx  = cnt_q[1:0] - 2'd1;
    wr_idx  = cnt_q[1:0] + 2'd1;
    rd_word = put_byte(data_q, rd_idx, bus.ram_din);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      owner_q     <= OWN_IF;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      io_gap_q    <= 2'd0;
      io_wr_q     <= 1'b0;
      data_q      <= ZeroWord;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (io_gap_q != 2'd0) io_gap_q <= io_gap_q - 2'd1;
      case (state_q)
        ST_IDLE: if (grant_mem || grant_if) begin
          owner_q  <= grant_mem ? OWN_MEM : OWN_IF;
          ram_a_q  <= grant_mem ? bus.mem_addr : bus.if_addr;
          n_q      <= grant_mem ? len_bytes(bus.mem_len) : 3'd4;
          cnt_q    <= 3'd0;
          data_q   <= ZeroWord;
          ram_wr_q <= grant_mem && bus.mem_we;
          io_wr_q  <= IoGuardEn && grant_mem && bus.mem_we && is_io;
          if (grant_mem && bus.mem_we) ram_dout_q <= get_byte(bus.mem_wdata, 2'd0);
        end
        ST_READ: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q != 3'd0) data_q <= rd_word;
          if (cnt_q + 3'd1 < n_q) ram_a_q <= ram_a_q + ADDR_W'(1);
          if (rd_last) begin
            if (owner_q == OWN_IF) begin
              if_done_q <= 1'b1;
              if_inst_q <= rd_word;
            end else begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= rd_word;
            end
          end
        end
        ST_WRITE: begin
          cnt_q <= cnt_q + 3'd1;
          if (wr_last) begin
            ram_wr_q   <= 1'b0;
            mem_done_q <= 1'b1;
            // Two counts: one for the done cycle, one for the extra idle cycle after an IO store.
            if (io_wr_q) io_gap_q <= 2'd2;
          end else begin
            ram_a_q    <= ram_a_q + ADDR_W'(1);
            ram_dout_q <= get_byte(bus.mem_wdata, wr_idx);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_done      = if_done_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.ram_a        = ram_a_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;
  assign bus.stallreq_if  = bus.if_req & ~if_done_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbiter/sequencer for the single byte-wide unified RAM port, shared by instruction fetch (IF) and the MEM stage.
- Serialises 1/2/4-byte little-endian accesses into per-byte RAM cycles.
- Returns the assembled word with a one-cycle done pulse.
- Drives stall requests to ctrl, which freezes the pipeline registers (incl. mem_wb) through stall_sign.

Parameters:
- ADDR_W, 32, address width of requests and RAM port.
- IO_SEL_BIT, 17, address bit pair [IO_SEL_BIT:IO_SEL_BIT-1]==2'b11 marks the IO region (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global ready; low freezes every register in this block.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  ADDR_W  fetch address (always a 4-byte read).
- if_done  out  1  one-cycle pulse: if_inst valid.
- if_inst  out  32  fetched word.
- mem_req  in  1  MEM-stage request; held with all mem_* inputs until mem_done.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  ADDR_W  byte address.
- mem_len  in  2  00=1 byte, 01=2, 10=4, 11 treated as 4.
- mem_wdata  in  32  store data, low bytes used.
- mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads.
- mem_rdata  out  32  load data, zero-extended (sign extension belongs to mem).
- stallreq_mem  out  1  combinational mem_req & ~mem_done.
- stallreq_if  out  1  combinational if_req & ~if_done.
- ram_din  in  8  RAM read byte.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM address.
- ram_wr  out  1  1=write.

Behaviour:
- Reset:
  - state=IDLE.
  - ram_a=0, ram_dout=0, ram_wr=0.
  - if_done=0, if_inst=0, mem_done=0, mem_rdata=0.
  - Byte counter=0.
- rdy=0: all state, counters and outputs hold. Cycle numbering below counts only rdy=1 cycles.
- FSM states:
  - IDLE, READ, WRITE.
  - Owner flag: IF or MEM.
- IDLE grant rules:
  - Grant is blocked in any cycle where if_done or mem_done is high, so the just-served requester can drop req.
  - Otherwise mem_req wins over if_req, including when both are high together.
  - Grant at end of cycle 0 latches the address into ram_a, n = byte count, cnt=0.
  - Next state is READ (ram_wr=0) or WRITE (ram_wr=1, ram_dout=wdata[7:0]).
- No preemption: a granted access runs to completion regardless of the other requester.
- RAM read latency: the byte for the ram_a presented in cycle c appears on ram_din in cycle c+1.
- READ:
  - ram_a = addr+i in cycle 1+i, for i<n.
  - In cycle 2+i, ram_din is captured into data byte i.
  - After the capture of byte n-1: state goes to IDLE, the owner's done=1 and its data are updated in cycle n+2.
  - Latency: 4-byte read, req in cycle 0, done in cycle 6; 1-byte read, done in cycle 3.
  - Unused upper bytes are 0.
- WRITE:
  - In cycle 1+i: ram_wr=1, ram_a=addr+i, ram_dout=wdata byte i.
  - In cycle n+1: ram_wr=0, mem_done=1, state IDLE.
  - Latency: 4-byte store, done in cycle 5.
- Addresses increment by plain ADDR_W-bit addition; wrap at 2^ADDR_W is allowed. No alignment check.
- Done pulses last exactly one cycle. if_inst and mem_rdata hold their values until the next completion.
- rst during an access:
  - Aborts next edge with no done pulse.
  - Partial stores may remain in RAM; this is accepted.
- if_req while a MEM access runs: waits. stallreq_if stays high.

Optional Feature:
- MEMCTRL_IO_GUARD_EN. Adds input io_buffer_full (1 bit).
- With the macro:
  - A MEM write whose address is in the IO region is not granted while io_buffer_full=1. IF may be granted meanwhile.
  - After any IO write completes, one extra idle cycle passes before the next grant.
- Without the macro: the port is absent; IO addresses are treated as ordinary RAM.

Decomposition:
- Shared defines package:
  - Memory-length codes (MemLen1/2/4).
  - FSM state encodings.
  - IO region select value 2'b11.
  - Existing RstEnable/ZeroWord reused.
- One natural sub-module: mem_ctrl_arb (combinational IDLE grant logic: priority, done blocking, IO guard).

Test Plan:
- if_req, if_addr=0x100, RAM 0x100..0x103 = 13,00,00,00 -> if_done in cycle 6, if_inst=0x00000013, ram_wr never 1.
- mem_req store, mem_len=10, addr=0x200, wdata=0xDEADBEEF -> ram_wr=1 in cycles 1-4 with bytes EF,BE,AD,DE at 0x200-0x203, mem_done in cycle 5.
- if_req and mem_req (1-byte load at 0x10=0x80) both high in cycle 0 -> mem_done in cycle 3 with mem_rdata=0x00000080. No grant in cycle 3. IF granted end of cycle 4, if_done in cycle 10.
- rdy low for 3 cycles mid word-read -> outputs frozen; completion delayed exactly 3 cycles with the same data.
- rst asserted in cycle 2 of a word store -> ram_wr=0 next cycle, no mem_done, all outputs at reset values.
- With MEMCTRL_IO_GUARD_EN: store to 0x30000 with io_buffer_full=1 for 5 cycles -> no grant until the cycle after it drops. A following if_req is granted one cycle later than normal.
